// File: rtl/burst_mem_pkg.sv
// Shared types and parameter-derived widths for the burst memory responder.
package burst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LAT   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte-offset bits inside one line.
  function automatic int line_off_f(input int data_w, input int burst_len);
    return $clog2((burst_len * data_w) / 8);
  endfunction

  function automatic int idx_w_f(input int depth_lines);
    return (depth_lines > 1) ? $clog2(depth_lines) : 1;
  endfunction

  function automatic int beat_w_f(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

  function automatic int cnt_w_f(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/burst_mem_if.sv
// Cacheline burst bus between the adaptor (master) and the memory responder (slave).
interface burst_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (output mem_read, mem_write, mem_addr, mem_wdata, input mem_rdata, mem_resp);
  modport slave  (input mem_read, mem_write, mem_addr, mem_wdata, output mem_rdata, mem_resp);
endinterface

// File: rtl/burst_mem_array.sv
// Single-port word store: synchronous write, registered read, no reset.
module burst_mem_array #(
  parameter int DATA_W = 64,
  parameter int WORDS  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_r [WORDS];

  // Write port and registered read port sharing one address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end
endmodule

// File: rtl/burst_mem_responder.sv
// Responder end of the cacheline burst protocol with fixed latency.
// Optional completed-burst counters are enabled by defining BURST_MEM_STATS_EN.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int BURST_LEN   = 4,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 8
) (
  input  logic        clk,
  input  logic        rst,
  burst_mem_if.slave  mem,
  output logic        busy,
  output logic        protocol_err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  localparam int LOFF   = line_off_f(DATA_W, BURST_LEN);
  localparam int IDX_W  = idx_w_f(DEPTH_LINES);
  localparam int BEAT_W = beat_w_f(BURST_LEN);
  localparam int CNT_W  = cnt_w_f(LATENCY);
  localparam int WA_W   = IDX_W + BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic              is_write_r, is_write_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [BEAT_W-1:0] beat_r, beat_s, beat_nxt_s;
  logic              resp_r, busy_r, err_r, err_s;
  logic              req_held_s, other_s, arr_we_s, rd_done_s, wr_done_s;
  logic [WA_W-1:0]   arr_addr_s;
  logic [DATA_W-1:0] arr_rdata_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^mem.mem_addr;
  assign beat_nxt_s    = beat_r + 1'b1;
  assign req_held_s    = is_write_r ? mem.mem_write : mem.mem_read;
  assign other_s       = is_write_r ? mem.mem_read : mem.mem_write;

  // Next-state, array control and error detection.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    is_write_s = is_write_r;
    cnt_s      = cnt_r;
    beat_s     = beat_r;
    err_s      = err_r;
    arr_we_s   = 1'b0;
    arr_addr_s = {idx_r, beat_r};
    rd_done_s  = 1'b0;
    wr_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // Read-ahead of beat 0 already starts here so LATENCY=1 still works.
        arr_addr_s = {mem.mem_addr[LOFF +: IDX_W], {BEAT_W{1'b0}}};
        if (mem.mem_read && mem.mem_write) begin
          err_s = 1'b1;
        end else if (mem.mem_read || mem.mem_write) begin
          idx_s      = mem.mem_addr[LOFF +: IDX_W];
          is_write_s = mem.mem_write;
          beat_s     = {BEAT_W{1'b0}};
          cnt_s      = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_s = BURST;
          end else begin
            state_s = LAT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LAT: begin
        err_s = err_r | other_s | ~req_held_s;
        if (!req_held_s) begin
          state_s = IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = BURST;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      BURST: begin
        err_s      = err_r | other_s | ~req_held_s;
        arr_addr_s = is_write_r ? {idx_r, beat_r} : {idx_r, beat_nxt_s};
        if (!req_held_s) begin
          state_s = IDLE;
        end else begin
          arr_we_s = is_write_r;
          if (beat_r == LAST_BEAT) begin
            beat_s    = {BEAT_W{1'b0}};
            state_s   = DONE;
            rd_done_s = ~is_write_r;
            wr_done_s = is_write_r;
          end else begin
            beat_s = beat_nxt_s;
          end
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      idx_r      <= {IDX_W{1'b0}};
      is_write_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      beat_r     <= {BEAT_W{1'b0}};
      resp_r     <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      is_write_r <= is_write_s;
      cnt_r      <= cnt_s;
      beat_r     <= beat_s;
      resp_r     <= (state_s == BURST);
      busy_r     <= (state_s != IDLE);
      err_r      <= err_s;
    end
  end

  burst_mem_array #(
    .DATA_W (DATA_W),
    .WORDS  (DEPTH_LINES * BURST_LEN),
    .AW     (WA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_s),
    .addr  (arr_addr_s),
    .wdata (mem.mem_wdata),
    .rdata (arr_rdata_s)
  );

  assign mem.mem_resp  = resp_r;
  assign mem.mem_rdata = resp_r ? arr_rdata_s : {DATA_W{1'b0}};
  assign busy          = busy_r;
  assign protocol_err  = err_r;

`ifdef BURST_MEM_STATS_EN
  logic [31:0] rd_count_r, wr_count_r;

  // Completed-burst counters, bumped on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_r <= 32'd0;
      wr_count_r <= 32'd0;
    end else begin
      rd_count_r <= rd_count_r + {31'd0, rd_done_s};
      wr_count_r <= wr_count_r + {31'd0, wr_done_s};
    end
  end

  assign rd_count = rd_count_r;
  assign wr_count = wr_count_r;
`else
  logic unused_done_s;
  assign unused_done_s = rd_done_s ^ wr_done_s;
  assign rd_count      = 32'd0;
  assign wr_count      = 32'd0;
`endif
endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: timing, data, aborts, reset and counters.
module tb_burst_mem_responder;
  localparam int LATENCY = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, protocol_err;
  logic [31:0] rd_count, wr_count;

  int checks   = 0;
  int failures = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;

  logic [63:0] exp_q [$];
  logic [63:0] model [int];
  logic [63:0] wbuf [4];

  always #5 clk = ~clk;

  burst_mem_if #(.ADDR_W(32), .DATA_W(64)) bus ();

  burst_mem_responder #(
    .ADDR_W(32), .DATA_W(64), .BURST_LEN(4), .DEPTH_LINES(256), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .mem(bus), .busy(busy), .protocol_err(protocol_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  task automatic set_wbuf(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] d);
    wbuf[0] = a; wbuf[1] = b; wbuf[2] = c; wbuf[3] = d;
  endtask

  task automatic idle_bus();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  // One transaction; drop_after >= 0 drops the request after that beat.
  task automatic run_txn(input string name, input bit wr, input logic [31:0] addr,
                         input int drop_after);
    int line_base, beat;
    bit finished;
    logic [63:0] exp_w;
    line_base = int'(addr[12:5]) * 4;
    if (!wr)
      for (int b = 0; b < 4; b++)
        if (drop_after < 0 || b <= drop_after) exp_q.push_back(model[line_base + b]);
    @(posedge clk); #1;
    bus.mem_addr = addr; bus.mem_read = !wr; bus.mem_write = wr; bus.mem_wdata = wbuf[0];
    beat = 0; finished = 1'b0;
    for (int n = 0; n < 40 && !finished; n++) begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        if (beat == 0) begin
          checks++;
          if (n != LATENCY) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, n, LATENCY);
          end
        end
        if (wr) model[line_base + beat] = wbuf[beat];
        else begin
          exp_w = exp_q.pop_front();
          checks++;
          if (bus.mem_rdata !== exp_w) begin
            failures++;
            $display("FAIL %s beat%0d rdata: got %h, want %h", name, beat, bus.mem_rdata, exp_w);
          end
        end
        beat++;
        if (drop_after >= 0 && beat == drop_after + 1) begin
          @(posedge clk); #1; idle_bus();
          @(negedge clk); @(negedge clk);
          checks++;
          if (bus.mem_resp !== 1'b0 || busy !== 1'b0 || protocol_err !== 1'b1) begin
            failures++;
            $display("FAIL %s abort: resp=%b busy=%b err=%b, want 0 0 1",
                     name, bus.mem_resp, busy, protocol_err);
          end
          finished = 1'b1;
        end else if (beat == 4) begin
          @(posedge clk); #1; idle_bus();
          @(negedge clk);
          checks++;
          if (bus.mem_resp !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s done: resp=%b busy=%b, want 0 1", name, bus.mem_resp, busy);
          end
          @(negedge clk);
          checks++;
          if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle busy: got %b, want 0", name, busy);
          end
          if (wr) exp_wr++; else exp_rd++;
          finished = 1'b1;
        end else begin
          @(posedge clk); #1; bus.mem_wdata = wbuf[beat];
        end
      end else begin
        checks++;
        if (bus.mem_rdata !== 64'd0) begin
          failures++;
          $display("FAIL %s quiet rdata: got %h, want 0", name, bus.mem_rdata);
        end
      end
    end
    if (!finished) begin
      checks++; failures++;
      $display("FAIL %s timeout: got %0d beats, want 4", name, beat);
      idle_bus();
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    idle_bus(); rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    exp_rd = 0; exp_wr = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_bus(); bus.mem_addr = 32'd0; bus.mem_wdata = 64'd0;
    #12;
    checks++;
    if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 64'd0 || busy !== 1'b0 ||
        protocol_err !== 1'b0 || rd_count !== 32'd0 || wr_count !== 32'd0) begin
      failures++;
      $display("FAIL reset: resp=%b rdata=%h busy=%b err=%b rd=%0d wr=%0d, want all 0",
               bus.mem_resp, bus.mem_rdata, busy, protocol_err, rd_count, wr_count);
    end
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_write_read();
    set_wbuf({8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}});
    run_txn("wr40", 1'b1, 32'h0000_0040, -1);
    run_txn("rd40", 1'b0, 32'h0000_0040, -1);
  endtask

  task automatic test_addr_map();
    run_txn("rd4c_unaligned", 1'b0, 32'h0000_004C, -1);
    run_txn("rd2040_wrap", 1'b0, 32'h0000_2040, -1);
    checks++;
    if (protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clean: got %b, want 0", protocol_err);
    end
  endtask

  task automatic test_both_requests();
    int seen;
    seen = 0;
    @(posedge clk); #1;
    bus.mem_addr = 32'h40; bus.mem_read = 1'b1; bus.mem_write = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_resp !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || protocol_err !== 1'b1) begin
      failures++;
      $display("FAIL both_req: resp cycles=%0d err=%b, want 0 1", seen, protocol_err);
    end
    @(posedge clk); #1; idle_bus();
    repeat (3) @(negedge clk);
    checks++;
    if (protocol_err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky: err=%b busy=%b, want 1 0", protocol_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.mem_addr = 32'h40; bus.mem_read = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_resp !== 1'b0 || bus.mem_rdata !== 64'd0 || busy !== 1'b0 ||
        protocol_err !== 1'b0 || rd_count !== 32'd0 || wr_count !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: resp=%b busy=%b err=%b rd=%0d wr=%0d, want all 0",
               bus.mem_resp, busy, protocol_err, rd_count, wr_count);
    end
    idle_bus();
    @(posedge clk); #1; rst = 1'b1;
    exp_rd = 0; exp_wr = 0;
    run_txn("rd_after_reset", 1'b0, 32'h0000_0040, -1);
  endtask

  task automatic test_abort_write();
    set_wbuf({8{8'hAA}}, {8{8'hAA}}, {8{8'hAA}}, {8{8'hAA}});
    run_txn("wr80_full", 1'b1, 32'h0000_0080, -1);
    checks++;
    if (protocol_err !== 1'b0) begin
      failures++;
      $display("FAIL err_before_abort: got %b, want 0", protocol_err);
    end
    set_wbuf({8{8'hBB}}, {8{8'hBB}}, {8{8'hBB}}, {8{8'hBB}});
    run_txn("wr80_abort", 1'b1, 32'h0000_0080, 1);
    run_txn("rd80_partial", 1'b0, 32'h0000_0080, -1);
  endtask

  task automatic test_stats();
    logic [31:0] want_rd, want_wr;
    apply_reset();
    set_wbuf(64'hC0, 64'hC1, 64'hC2, 64'hC3);
    run_txn("st_wr100", 1'b1, 32'h0000_0100, -1);
    set_wbuf(64'hD0, 64'hD1, 64'hD2, 64'hD3);
    run_txn("st_wr120", 1'b1, 32'h0000_0120, -1);
    run_txn("st_rd100", 1'b0, 32'h0000_0100, -1);
    run_txn("st_rd120", 1'b0, 32'h0000_0120, -1);
    run_txn("st_rd40", 1'b0, 32'h0000_0040, -1);
    run_txn("st_rd_abort", 1'b0, 32'h0000_0100, 1);
`ifdef BURST_MEM_STATS_EN
    want_rd = 32'(exp_rd);
    want_wr = 32'(exp_wr);
`else
    want_rd = 32'd0;
    want_wr = 32'd0;
`endif
    checks++;
    if (rd_count !== want_rd || wr_count !== want_wr) begin
      failures++;
      $display("FAIL stats: rd=%0d wr=%0d, want %0d %0d", rd_count, wr_count, want_rd, want_wr);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addr_map();
    test_both_requests();
    test_reset_mid();
    test_abort_write();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
